// File: rtl/can_bit_destuffer_pkg.sv
// can_pkg: shared CAN bit-stream types and stuffing defaults for destuffer and frame controller.
package can_pkg;
   localparam int CNT_W            = 3;
   localparam int STUFF_RUN_DEF    = 5;
   localparam int FIXED_PERIOD_DEF = 4;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef enum logic [1:0] {IDLE, COUNT, FIXED, ERR} state_e;
endpackage

// File: rtl/can_bit_destuffer_if.sv
// can_bit_destuffer_if: sample-point bit stream into the destuffer and destuffed results out.
interface can_bit_destuffer_if;
   import can_pkg::*;
   logic sp;
   logic rx_bit;
   logic bs_on;
   logic fd_fixed;
   logic bit_out;
   logic bit_valid;
   logic is_stuff;
   logic stuff_err;
   cnt_t stuff_cnt;
   modport master (output sp, rx_bit, bs_on, fd_fixed, input bit_out, bit_valid, is_stuff, stuff_err, stuff_cnt);
   modport slave  (input sp, rx_bit, bs_on, fd_fixed, output bit_out, bit_valid, is_stuff, stuff_err, stuff_cnt);
endinterface

// File: rtl/can_bit_destuffer.sv
// can_bit_destuffer: removes dynamic and FD fixed stuff bits at each sample point and flags stuff violations.
module can_bit_destuffer
   import can_pkg::*;
#(
   parameter int STUFF_RUN    = STUFF_RUN_DEF,
   parameter int FIXED_PERIOD = FIXED_PERIOD_DEF
) (
   input logic clk,
   input logic reset,
   can_bit_destuffer_if.slave bus
);
   state_e state, state_n;
   cnt_t run, run_n, fcnt, fcnt_n, cnt, cnt_n;
   logic last, last_n, out, out_n, valid, valid_n, stuff, stuff_n, err, err_n, fix;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         run   <= '0;
         fcnt  <= '0;
         cnt   <= '0;
         last  <= 1'b1;
         out   <= 1'b1;
         valid <= 1'b0;
         stuff <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         run   <= run_n;
         fcnt  <= fcnt_n;
         cnt   <= cnt_n;
         last  <= last_n;
         out   <= out_n;
         valid <= valid_n;
         stuff <= stuff_n;
         err   <= err_n;
      end
   end
   always_comb begin
      state_n = state;
      run_n   = run;
      fcnt_n  = fcnt;
      cnt_n   = cnt;
      last_n  = last;
      out_n   = out;
      valid_n = 1'b0;
      stuff_n = stuff;
      err_n   = 1'b0;
      fix     = 1'b0;
      if (bus.sp) begin
         out_n   = bus.rx_bit;
         valid_n = 1'b1;
         stuff_n = 1'b0;
         case (state)
            IDLE: if (bus.bs_on) begin
               state_n = COUNT;
               last_n  = bus.rx_bit;
               run_n   = cnt_t'(1);
               cnt_n   = '0;
            end
            COUNT: if (!bus.bs_on) begin
               state_n = IDLE;
               run_n   = '0;
            end else if (run == cnt_t'(STUFF_RUN)) begin
               valid_n = 1'b0;
               stuff_n = bus.rx_bit != last;
               err_n   = bus.rx_bit == last;
               state_n = err_n ? ERR : COUNT;
               run_n   = err_n ? run : cnt_t'(1);
               last_n  = bus.rx_bit;
               cnt_n   = err_n ? cnt : cnt_t'(cnt + 1'b1);
            end else if (bus.fd_fixed) begin
               fix = 1'b1;
            end else begin
               run_n  = bus.rx_bit == last ? cnt_t'(run + 1'b1) : cnt_t'(1);
               last_n = bus.rx_bit;
            end
            FIXED: if (!bus.bs_on) begin
               state_n = IDLE;
               run_n   = '0;
            end else if (!bus.fd_fixed) begin
               state_n = COUNT;
               run_n   = cnt_t'(1);
               last_n  = bus.rx_bit;
            end else if (fcnt == cnt_t'(FIXED_PERIOD)) begin
               fix = 1'b1;
            end else begin
               fcnt_n = cnt_t'(fcnt + 1'b1);
               last_n = bus.rx_bit;
            end
            default: begin
               valid_n = 1'b0;
               state_n = bus.bs_on ? ERR : IDLE;
               run_n   = bus.bs_on ? run : '0;
            end
         endcase
         // fixed stuff bit: must complement the preceding bit, reloads the data-bit period
         if (fix) begin
            valid_n = 1'b0;
            stuff_n = bus.rx_bit != last;
            err_n   = bus.rx_bit == last;
            state_n = err_n ? ERR : FIXED;
            fcnt_n  = '0;
            last_n  = bus.rx_bit;
         end
      end
   end
   assign bus.bit_out   = out;
   assign bus.bit_valid = valid;
   assign bus.is_stuff  = stuff;
   assign bus.stuff_err = err;
   assign bus.stuff_cnt = cnt;
endmodule

// File: tb/tb_can_bit_destuffer.sv
// tb_can_bit_destuffer: directed vector table, corner sequences and randomized stream against a rule-level model.
module tb_can_bit_destuffer;
   localparam int SR = 5;
   localparam int FP = 4;
   typedef struct {
      bit rx, bs, fd, v, s, e;
      logic [2:0] c;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   can_bit_destuffer_if bus();
   can_bit_destuffer #(.STUFF_RUN(SR), .FIXED_PERIOD(FP)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // model: mode 0 idle, 1 dynamic, 2 fixed, 3 error; hist holds the current run/stream tail
   int m;
   bit hist[$];
   int fdn;
   logic e_out, e_valid, e_stuff, e_err;
   logic [2:0] e_cnt;
   vec_t tbl[$];
   function automatic logic [6:0] act();
      return {bus.bit_out, bus.bit_valid, bus.is_stuff, bus.stuff_err, bus.stuff_cnt};
   endfunction
   task automatic chk(input string name, input logic [6:0] a, input logic [6:0] x);
      n_tests++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s at %0t: got out/valid/stuff/err/cnt=%b, required %b", name, $time, a, x);
      end
   endtask
   function automatic bit tail_eq();
      if (hist.size() < SR) return 1'b0;
      for (int i = 1; i < SR; i++)
         if (hist[hist.size()-1-i] != hist[$]) return 1'b0;
      return 1'b1;
   endfunction
   task automatic model_reset();
      m = 0; hist = {}; fdn = 0;
      e_out = 1'b1; e_valid = 1'b0; e_stuff = 1'b0; e_err = 1'b0; e_cnt = 3'd0;
   endtask
   task automatic fixed_bit(input bit rx);
      e_valid = 1'b0;
      if (rx != hist[$]) begin
         e_stuff = 1'b1; m = 2; fdn = 0; hist.push_back(rx);
      end else begin
         e_err = 1'b1; m = 3;
      end
   endtask
   task automatic model(input bit rx, input bit bs, input bit fd);
      e_out = rx; e_valid = 1'b1; e_stuff = 1'b0; e_err = 1'b0;
      case (m)
         0: if (bs) begin m = 1; hist = {rx}; e_cnt = 3'd0; end
         1: if (!bs) m = 0;
            else if (tail_eq()) begin
               e_valid = 1'b0;
               if (rx != hist[$]) begin e_stuff = 1'b1; e_cnt++; hist = {rx}; end
               else begin e_err = 1'b1; m = 3; end
            end else if (fd) fixed_bit(rx);
            else hist.push_back(rx);
         2: if (!bs) m = 0;
            else if (!fd) begin m = 1; hist = {rx}; end
            else if (fdn == FP) fixed_bit(rx);
            else begin fdn++; hist.push_back(rx); end
         default: begin e_valid = 1'b0; if (!bs) m = 0; end
      endcase
      if (hist.size() > 8) void'(hist.pop_front());
   endtask
   task automatic sp_step(input bit rx, input bit bs, input bit fd);
      bus.sp = 1'b1; bus.rx_bit = rx; bus.bs_on = bs; bus.fd_fixed = fd;
      @(negedge clk);
      bus.sp = 1'b0;
      model(rx, bs, fd);
      chk("model", act(), {e_out, e_valid, e_stuff, e_err, e_cnt});
   endtask
   task automatic gap();
      bus.rx_bit = 1'($urandom);
      bus.bs_on = 1'($urandom);
      bus.fd_fixed = 1'($urandom);
      @(negedge clk);
      chk("hold", act(), {e_out, 1'b0, e_stuff, 1'b0, e_cnt});
   endtask
   task automatic add(input bit rx, bs, fd, v, s, e, input logic [2:0] c, input int n);
      vec_t t;
      t.rx = rx; t.bs = bs; t.fd = fd; t.v = v; t.s = s; t.e = e; t.c = c;
      repeat (n) tbl.push_back(t);
   endtask
   initial begin
      bit b, rx, bs, fd, prev;
      add(0,1,0, 1,0,0, 3'd0, 5);
      add(1,1,0, 0,1,0, 3'd1, 1);
      add(0,1,0, 1,0,0, 3'd1, 1);
      add(1,0,0, 1,0,0, 3'd1, 1);
      add(1,1,0, 1,0,0, 3'd0, 5);
      add(1,1,0, 0,0,1, 3'd0, 1);
      add(1,0,0, 0,0,0, 3'd0, 1);
      add(0,0,0, 1,0,0, 3'd0, 1);
      add(1,1,0, 1,0,0, 3'd0, 1);
      add(0,1,1, 0,1,0, 3'd0, 1);
      add(1,1,1, 1,0,0, 3'd0, 2);
      add(0,1,1, 1,0,0, 3'd0, 1);
      add(1,1,1, 1,0,0, 3'd0, 1);
      add(0,1,1, 0,1,0, 3'd0, 1);
      add(0,1,1, 1,0,0, 3'd0, 4);
      add(0,1,1, 0,0,1, 3'd0, 1);
      add(1,0,0, 0,0,0, 3'd0, 1);
      add(1,1,0, 1,0,0, 3'd0, 1);
      add(0,1,1, 0,1,0, 3'd0, 1);
      add(0,1,1, 1,0,0, 3'd0, 1);
      add(0,1,0, 1,0,0, 3'd0, 5);
      add(1,1,0, 0,1,0, 3'd1, 1);
      add(0,0,0, 1,0,0, 3'd1, 1);
      bus.sp = 1'b0; bus.rx_bit = 1'b1; bus.bs_on = 1'b0; bus.fd_fixed = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset", act(), 7'b1000000);
      reset = 1'b0;
      @(negedge clk);
      foreach (tbl[i]) begin
         sp_step(tbl[i].rx, tbl[i].bs, tbl[i].fd);
         chk($sformatf("vec%0d", i), act(), {tbl[i].rx, tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].c});
      end
      b = 1'b0;
      repeat (5) sp_step(b, 1, 0);
      for (int k = 1; k <= 9; k++) begin
         b = ~b;
         sp_step(b, 1, 0);
         if (k == 8) chk("wrap0", {4'd0, bus.stuff_cnt}, 7'd0);
         if (k == 9) chk("wrap1", {4'd0, bus.stuff_cnt}, 7'd1);
         repeat (4) sp_step(b, 1, 0);
      end
      sp_step(~b, 0, 0);
      repeat (4) sp_step(0, 1, 0);
      #2 reset = 1'b1;
      #1 chk("async_rst", act(), 7'b1000000);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) begin
         sp_step(0, 1, 0);
         chk("post_rst", act(), 7'b0100000);
      end
      repeat (20) gap();
      prev = 1'b0; fd = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) fd = ~fd;
         bs = $urandom_range(0, 29) != 0;
         rx = ($urandom_range(0, 3) == 0) ? ~prev : prev;
         if (bs && ((m == 1 && (tail_eq() || fd)) || (m == 2 && fd && fdn == FP)))
            rx = ($urandom_range(0, 7) != 0) ? ~hist[$] : hist[$];
         prev = rx;
         sp_step(rx, bs, fd);
         repeat ($urandom_range(0, 2)) gap();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/can_bit_destuffer.md
CAN_BIT_DESTUFFER -- requirements
Module: can_bit_destuffer

Interface
REQ-001 The block SHALL have parameter STUFF_RUN, default 5, giving the equal-bit run length that forces a stuff bit.
REQ-002 The block SHALL have parameter FIXED_PERIOD, default 4, giving the data bits between fixed stuff bits in FD mode.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port sp, input, 1 bit: one-clk sample-point strobe from bit timing.
REQ-006 The block SHALL have port rx_bit, input, 1 bit: CAN_RX level, valid when sp=1.
REQ-007 The block SHALL have port bs_on, input, 1 bit: destuffing enable from the frame controller, sampled at sp.
REQ-008 The block SHALL have port fd_fixed, input, 1 bit: FD CRC-field fixed-stuff mode request, sampled at sp.
REQ-009 The block SHALL have port bit_out, output, 1 bit: last sampled bit.
REQ-010 The block SHALL have port bit_valid, output, 1 bit: one-clk pulse; bit_out is a data (non-stuff) bit.
REQ-011 The block SHALL have port is_stuff, output, 1 bit: level; last sampled bit was a stuff bit; held until next sp.
REQ-012 The block SHALL have port stuff_err, output, 1 bit: one-clk pulse on a stuff rule violation.
REQ-013 The block SHALL have port stuff_cnt, output, 3 bits: dynamic stuff bits removed this frame, mod 8.

Function
REQ-014 Outputs SHALL be registered and update exactly one clk after the sp cycle; no output changes on cycles without sp.
REQ-015 The FSM SHALL have states IDLE, COUNT, FIXED and ERR.
REQ-016 In IDLE, each sp SHALL give bit_valid=1, is_stuff=0, bit_out=rx_bit.
REQ-017 An sp with bs_on=1 in IDLE SHALL move to COUNT, with last=rx_bit, run=1 and stuff_cnt=0; that bit is data.
REQ-018 In COUNT with run<STUFF_RUN, rx_bit==last SHALL increment run, rx_bit!=last SHALL set run=1 and last=rx_bit, and the bit SHALL be data.
REQ-019 In COUNT with run==STUFF_RUN, rx_bit!=last SHALL be a stuff bit: is_stuff=1, bit_valid=0, run=1, last=rx_bit, stuff_cnt+1 (wrapping 7->0).
REQ-020 In COUNT with run==STUFF_RUN, rx_bit==last SHALL cause stuff_err=1, bit_valid=0 and a move to ERR.
REQ-021 A stuff bit SHALL count as the first bit of the next run.
REQ-022 An sp in COUNT with fd_fixed=1 SHALL move to FIXED; that bit is a fixed stuff bit that must be the complement of last.
REQ-023 In FIXED, after every FIXED_PERIOD data bits, the next bit SHALL be a fixed stuff bit that must be the complement of the preceding bit.
REQ-024 A correct fixed stuff bit SHALL give is_stuff=1, bit_valid=0 and SHALL NOT change stuff_cnt.
REQ-025 A wrong fixed stuff bit SHALL cause stuff_err=1 and a move to ERR.
REQ-026 The dynamic run rule SHALL be ignored in FIXED.
REQ-027 FIXED SHALL return to COUNT with run=1 on an sp with fd_fixed=0.
REQ-028 In ERR, bit_valid, is_stuff and stuff_err SHALL be 0; an sp with bs_on=0 SHALL move to IDLE.
REQ-029 An sp with bs_on=0 in COUNT or FIXED SHALL move to IDLE, clear run, and treat the bit as data.
REQ-030 Priority at one sp SHALL be: bs_on=0, then stuff check, then fd_fixed entry.
REQ-031 An rx_bit change without sp SHALL have no effect.
REQ-032 Arithmetic: run is 3 bits and saturates at STUFF_RUN; the fixed-period counter is 3 bits and reloads at each fixed stuff bit.

Reset
REQ-033 On reset: state=IDLE, bit_out=1, bit_valid=0, is_stuff=0, stuff_err=0, stuff_cnt=0, run=0, last=1.
REQ-034 Reset mid-frame SHALL abort immediately; the first sp after release behaves as IDLE.

Structure
REQ-035 Package can_pkg SHALL hold the state enum, STUFF_RUN/FIXED_PERIOD defaults and the 3-bit counter widths, shared with the frame controller.
REQ-036 The block SHALL be a single module with no sub-module; the FSM and counters are inline.

Verification
REQ-037 bs_on=1, bits 0 0 0 0 0 1 0 -> 6th bit is_stuff=1, bit_valid=0, stuff_cnt=1; 7th bit data, run=1.
REQ-038 bs_on=1, bits 1 1 1 1 1 1 -> stuff_err pulse on 6th bit, ERR; bs_on=0 at next sp -> IDLE.
REQ-039 Nine runs of five equal bits with alternating stuff bits -> stuff_cnt wraps 7->0->1.
REQ-040 fd_fixed=1 after last=1, bits 0 d d d d 1(complement of 4th d) -> both stuff bits flagged, stuff_cnt unchanged; a wrong fixed bit -> stuff_err.
REQ-041 Reset asserted during a run of 4 -> all outputs at reset values; after release, 2 more equal bits -> no stuff flagged (IDLE).
REQ-042 rx_bit toggling with sp=0 for 20 clks -> no output change.
